// File: rtl/serializer_pkg.sv
// Shared definitions for the bit serializer and the serial detector benches.
//   state_t  : serializer FSM encoding (IDLE / SHIFT)
//   PAT_0110 : reference pattern used by the detector benches
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] PAT_0110 = 4'b0110;

endpackage

// File: rtl/bit_serializer_tick_div.sv
// Bit-period divider: dcnt runs 0..DIV-1 while enabled and tick pulses for
// one cycle on the last count, marking the edge where the serial bit advances.
// Ports:
//   clk, rst : clock, async active-high reset
//   clr      : restart the bit period (word load)
//   en       : count enable (FSM in SHIFT)
//   tick     : one-cycle pulse when dcnt = DIV-1 and enabled
module tick_div #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);

  logic [DW-1:0] dcnt;

  assign tick = en && (dcnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcnt <= '0;
    end else if (clr || tick) begin
      dcnt <= '0;
    end else if (en) begin
      dcnt <= dcnt + 1'b1;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end. Words arrive over valid/ready into a
// one-word holding register and are shifted out one bit per DIV cycles.
// The held word loads on the end-of-word edge, so words stream gap-free.
//
// state | meaning
// IDLE  | nothing shifting; loads the held word as soon as one is present
// SHIFT | o carries the head bit of the shift register
//
// Ports:
//   clk, rst  : clock, async active-high reset
//   in_data   : parallel word, sampled only on a transfer edge
//   in_valid  : in_data offered
//   in_ready  : holding register empty (registered, no path from in_valid)
//   o         : serial bit, 0 when o_valid = 0
//   o_valid   : o carries a word bit
//   busy      : a word is shifting or one is held
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int W         = 8,
  parameter int DIV       = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         o,
  output logic         o_valid,
  output logic         busy
);

  localparam int BW = $clog2(W);
  localparam logic [BW-1:0] BLAST = BW'(W - 1);

  state_t        state, state_n;
  logic [W-1:0]  sreg, sreg_n, hold_reg;
  logic          hold_full;
  logic [BW-1:0] bcnt;
  logic          load, shift, tick, accept, head_n;
  logic          o_q, o_valid_q;

  assign in_ready = !hold_full;
  assign accept   = in_valid && !hold_full;
  assign busy     = (state == SHIFT) || hold_full;
  assign o        = o_q;
  assign o_valid  = o_valid_q;

  tick_div #(.DIV(DIV)) u_tick_div (
    .clk  (clk),
    .rst  (rst),
    .clr  (load),
    .en   (state == SHIFT),
    .tick (tick)
  );

  always_comb begin
    state_n = state;
    load    = 1'b0;
    shift   = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bcnt == BLAST) begin
            // End of word: chain the held word on this same edge if present.
            if (hold_full) load = 1'b1;
            else           state_n = IDLE;
          end else begin
            shift = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    sreg_n = sreg;
    if (load) begin
      sreg_n = hold_reg;
    end else if (shift) begin
      sreg_n = (MSB_FIRST != 0) ? {sreg[W-2:0], 1'b0} : {1'b0, sreg[W-1:1]};
    end
    head_n = (MSB_FIRST != 0) ? sreg_n[W-1] : sreg_n[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sreg      <= '0;
      hold_reg  <= '0;
      hold_full <= 1'b0;
      bcnt      <= '0;
      o_q       <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      // accept and load are exclusive: load needs hold_full, accept needs it clear.
      if (accept) begin
        hold_reg  <= in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      if (load)       bcnt <= '0;
      else if (shift) bcnt <= bcnt + 1'b1;
      // Outputs are registered from the next-state view so they track sreg exactly.
      o_valid_q <= (state_n == SHIFT);
      o_q       <= (state_n == SHIFT) && head_n;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;
  import serializer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // a: W=4 DIV=1 MSB-first   b: W=4 DIV=3 MSB-first
  // c: W=8 DIV=1 LSB-first   d: W=8 DIV=2 MSB-first
  logic [3:0] a_data = '0, b_data = '0;
  logic [7:0] c_data = '0, d_data = '0;
  logic a_valid = 0, b_valid = 0, c_valid = 0, d_valid = 0;
  logic a_rdy, a_o, a_ov, a_busy;
  logic b_rdy, b_o, b_ov, b_busy;
  logic c_rdy, c_o, c_ov, c_busy;
  logic d_rdy, d_o, d_ov, d_busy;

  bit_serializer #(.W(4), .DIV(1), .MSB_FIRST(1)) u_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
    .o(a_o), .o_valid(a_ov), .busy(a_busy));
  bit_serializer #(.W(4), .DIV(3), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
    .o(b_o), .o_valid(b_ov), .busy(b_busy));
  bit_serializer #(.W(8), .DIV(1), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_rdy),
    .o(c_o), .o_valid(c_ov), .busy(c_busy));
  bit_serializer #(.W(8), .DIV(2), .MSB_FIRST(1)) u_d (
    .clk(clk), .rst(rst), .in_data(d_data), .in_valid(d_valid), .in_ready(d_rdy),
    .o(d_o), .o_valid(d_ov), .busy(d_busy));

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({a_o, a_ov, a_busy, a_rdy} !== 4'b0001) begin
      fails++; $display("FAIL reset_a got %b want 0001", {a_o, a_ov, a_busy, a_rdy});
    end
    tests++;
    if ({b_o, b_ov, b_busy, b_rdy} !== 4'b0001) begin
      fails++; $display("FAIL reset_b got %b want 0001", {b_o, b_ov, b_busy, b_rdy});
    end
    tests++;
    if ({c_o, c_ov, c_busy, c_rdy} !== 4'b0001) begin
      fails++; $display("FAIL reset_c got %b want 0001", {c_o, c_ov, c_busy, c_rdy});
    end
    tests++;
    if ({d_o, d_ov, d_busy, d_rdy} !== 4'b0001) begin
      fails++; $display("FAIL reset_d got %b want 0001", {d_o, d_ov, d_busy, d_rdy});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [3:0] exp_w;
    logic [3:0] hist;
    int yat;
    exp_w = 4'b0110;
    hist  = 4'b0000;
    yat   = -1;
    a_valid = 1'b1;
    a_data  = 4'b0110;
    @(negedge clk);
    a_valid = 1'b0;
    tests++;
    if ({a_ov, a_busy} !== 2'b01) begin
      fails++; $display("FAIL single_latency got ov,busy=%b want 01", {a_ov, a_busy});
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tests++;
      if ({a_ov, a_o} !== {1'b1, exp_w[3-i]}) begin
        fails++; $display("FAIL single_bit%0d got ov,o=%b want 1%b", i, {a_ov, a_o}, exp_w[3-i]);
      end
      hist = {hist[2:0], a_o};
      if (a_ov && hist == PAT_0110 && yat < 0) yat = i;
    end
    tests++;
    if (yat !== 3) begin
      fails++; $display("FAIL single_detect got y at bit %0d want 3", yat);
    end
    @(negedge clk);
    tests++;
    if ({a_ov, a_o, a_busy} !== 3'b000) begin
      fails++; $display("FAIL single_end got ov,o,busy=%b want 000", {a_ov, a_o, a_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  stream;
    logic [10:0] exp_rdy;
    logic        ev, eo;
    stream  = 8'b0110_1011;
    exp_rdy = 11'b11111000101;   // bit k: in_ready at negedge k
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      ev = (k >= 2) && (k <= 9);
      eo = ev ? stream[7-(k-2)] : 1'b0;
      tests++;
      if ({a_ov, a_o} !== {ev, eo}) begin
        fails++; $display("FAIL b2b_bit k=%0d got ov,o=%b want %b", k, {a_ov, a_o}, {ev, eo});
      end
      tests++;
      if (a_rdy !== exp_rdy[k]) begin
        fails++; $display("FAIL b2b_ready k=%0d got %b want %b", k, a_rdy, exp_rdy[k]);
      end
      a_valid = (k <= 2);
      a_data  = (k == 0) ? 4'b0110 : 4'b1011;
    end
    a_valid = 1'b0;
  endtask

  task automatic test_slow();
    logic [3:0] w;
    logic ev, eo;
    w = 4'b1001;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1) begin
        ev = (k >= 2) && (k <= 13);
        eo = ev ? w[3-(k-2)/3] : 1'b0;
        tests++;
        if ({b_ov, b_o} !== {ev, eo}) begin
          fails++; $display("FAIL slow_bit k=%0d got ov,o=%b want %b", k, {b_ov, b_o}, {ev, eo});
        end
      end
      b_valid = (k == 0);
      b_data  = 4'b1001;
    end
    tests++;
    if (b_busy !== 1'b0) begin
      fails++; $display("FAIL slow_idle got busy=%b want 0", b_busy);
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    logic ev, eo;
    w = 8'hA5;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1) begin
        ev = (k >= 2) && (k <= 9);
        eo = ev ? w[k-2] : 1'b0;
        tests++;
        if ({c_ov, c_o} !== {ev, eo}) begin
          fails++; $display("FAIL lsb_bit k=%0d got ov,o=%b want %b", k, {c_ov, c_o}, {ev, eo});
        end
      end
      c_valid = (k == 0);
      c_data  = 8'hA5;
    end
  endtask

  task automatic test_reset_mid();
    int highs;
    highs = 0;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk);
      d_valid = (k <= 2);
      d_data  = (k == 0) ? 8'hFF : 8'hC3;
    end
    // negedge 8: bit 3 of 8'hFF is on the line, 8'hC3 held
    tests++;
    if ({d_ov, d_o, d_busy, d_rdy} !== 4'b1110) begin
      fails++; $display("FAIL rstmid_before got ov,o,busy,rdy=%b want 1110", {d_ov, d_o, d_busy, d_rdy});
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({d_o, d_ov, d_busy, d_rdy} !== 4'b0001) begin
      fails++; $display("FAIL rstmid_async got o,ov,busy,rdy=%b want 0001", {d_o, d_ov, d_busy, d_rdy});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (d_ov || d_o || d_busy) highs++;
    end
    tests++;
    if (highs !== 0) begin
      fails++; $display("FAIL rstmid_after got %0d active cycles want 0", highs);
    end
  endtask

  task automatic test_stall();
    logic [3:0]  d [7];
    logic [11:0] stream;
    logic ev, eo;
    d = '{4'h9, 4'h2, 4'h6, 4'hF, 4'h0, 4'hE, 4'hB};
    stream = 12'b1001_0110_1011;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      if (k >= 1) begin
        ev = (k >= 2) && (k <= 13);
        eo = ev ? stream[11-(k-2)] : 1'b0;
        tests++;
        if ({a_ov, a_o} !== {ev, eo}) begin
          fails++; $display("FAIL stall_bit k=%0d got ov,o=%b want %b", k, {a_ov, a_o}, {ev, eo});
        end
      end
      a_valid = (k <= 6);
      a_data  = (k <= 6) ? d[k] : 4'h0;
    end
    a_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_slow();
    test_lsb_first();
    test_reset_mid();
    test_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
